// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback port scheduler.
package wb_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_RA_W = 5;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [WB_RA_W-1:0] rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_ld_fifo.sv
// Load-return buffer: small FIFO of {rd, data} with occupancy count and flags.
// The caller must not push when full nor pop when empty.
module wb_ld_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  wb_entry_t                  push_data,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Storage needs no reset: an entry is only read once count says it is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap at DEPTH (which need not be a power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_sched.sv
// Writeback port scheduler: shares the register-file write port between ALU
// results and buffered load returns, with an aging rule so loads cannot starve.
// Optional macro WB_SCOREBOARD_EN adds a per-register pending-load scoreboard.
module wb_port_sched
    import wb_pkg::*;
#(
    parameter int LD_DEPTH = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_valid,
    input  logic [WB_RA_W-1:0] alu_rd,
    input  logic [WB_XLEN-1:0] alu_result,
    output logic               alu_ready,
    input  logic               ld_valid,
    input  logic [WB_RA_W-1:0] ld_rd,
    input  logic [WB_XLEN-1:0] ld_data,
    output logic               ld_ready,
`ifdef WB_SCOREBOARD_EN
    input  logic               ld_issue,
    input  logic [WB_RA_W-1:0] ld_issue_rd,
    output logic [WB_XLEN-1:0] busy,
`endif
    output logic               WE3,
    output logic [WB_RA_W-1:0] A3,
    output logic [WB_XLEN-1:0] WD3,
    output logic               MemOrReg,
    output logic               ld_pending
);

    localparam int AW = $clog2(MAX_WAIT + 1);
    localparam int CW = $clog2(LD_DEPTH + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);

    wb_entry_t       head;
    wb_entry_t       win;
    wb_src_e         win_src;
    wb_src_e         src_q;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;
    logic            push;
    logic            load_grant;
    logic            alu_grant;
    logic [AW-1:0]   age;

    assign ld_ready   = !full;
    assign push       = ld_valid && ld_ready;
    assign ld_pending = !empty;
    assign MemOrReg   = src_q;

    wb_ld_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ('{rd: ld_rd, data: ld_data}),
        .pop       (load_grant),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    // Arbitration: the head load wins when idle ALU, full buffer, aged out, or a
    // same-rd WAW hazard (older load must write first); otherwise the ALU wins.
    always_comb begin
        load_grant = !empty && (!alu_valid || full || (age >= AGE_MAX) ||
                                ((head.rd == alu_rd) && (alu_rd != '0)));
        alu_grant  = alu_valid && !load_grant;
        alu_ready  = alu_grant;
        win        = head;
        win_src    = WB_SRC_MEM;
        if (!load_grant) begin
            win.rd   = alu_rd;
            win.data = alu_result;
            win_src  = WB_SRC_ALU;
        end
    end

    // Head age: counts cycles the head is passed over, saturating at MAX_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     age <= '0;
        else if (empty || load_grant)   age <= '0;
        else if (age < AGE_MAX)         age <= age + 1'b1;
    end

    // Write-port registers: one-cycle WE3 pulse per grant; rd 0 is consumed silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WE3   <= 1'b0;
            A3    <= '0;
            WD3   <= '0;
            src_q <= WB_SRC_ALU;
        end else if (load_grant || alu_grant) begin
            WE3   <= (win.rd != '0);
            A3    <= win.rd;
            WD3   <= win.data;
            src_q <= win_src;
        end else begin
            WE3   <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [WB_XLEN-1:0] busy_nxt;

    // Scoreboard next state: clear on load grant, then set on issue so set wins.
    always_comb begin
        busy_nxt = busy;
        if (load_grant) busy_nxt[head.rd] = 1'b0;
        if (ld_issue)   busy_nxt[ld_issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end
`endif

endmodule

// File: tb/tb_wb_port_sched.sv
// Directed self-checking bench for wb_port_sched (default build, LD_DEPTH=2, MAX_WAIT=4).
module tb_wb_port_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_result = '0;
    logic        alu_ready;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        MemOrReg;
    logic        ld_pending;

    int checks = 0;
    int errors = 0;

    wb_port_sched #(.LD_DEPTH(2), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_result (alu_result),
        .alu_ready  (alu_ready),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .MemOrReg   (MemOrReg),
        .ld_pending (ld_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_we3", 32'(WE3), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd3", WD3, 32'd0);
        chk("rst_mor", 32'(MemOrReg), 32'd0);
        chk("rst_pend", 32'(ld_pending), 32'd0);
        chk("rst_ldrdy", 32'(ld_ready), 32'd1);
        chk("rst_alurdy", 32'(alu_ready), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_we3", 32'(WE3), 32'd0);

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'h1234_5678;
        #1 chk("alu_ready", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        chk("alu_we3", 32'(WE3), 32'd1);
        chk("alu_a3", 32'(A3), 32'd3);
        chk("alu_wd3", WD3, 32'h1234_5678);
        chk("alu_mor", 32'(MemOrReg), 32'd0);
        step();
        chk("idle_we3", 32'(WE3), 32'd0);
        chk("idle_a3_hold", 32'(A3), 32'd3);

        // Load only: two cycles from accept to write
        ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hDEAD_BEEF;
        #1 chk("ld_ready", 32'(ld_ready), 32'd1);
        step();
        ld_valid = 1'b0;
        chk("ld_pend1", 32'(ld_pending), 32'd1);
        chk("ld_nobypass", 32'(WE3), 32'd0);
        step();
        chk("ld_we3", 32'(WE3), 32'd1);
        chk("ld_a3", 32'(A3), 32'd5);
        chk("ld_wd3", WD3, 32'hDEAD_BEEF);
        chk("ld_mor", 32'(MemOrReg), 32'd1);
        chk("ld_pend0", 32'(ld_pending), 32'd0);

        // Starvation: ALU streams, load forced on its 5th eligible cycle
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'hA5A5_0009;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_result = 32'h100;
        step();
        ld_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            alu_result = 32'h100 + 32'(k);
            #1 chk("starve_alurdy", 32'(alu_ready), 32'd1);
            step();
            chk("starve_alu_wd3", WD3, 32'h100 + 32'(k));
        end
        #1 chk("starve_forced", 32'(alu_ready), 32'd0);
        step();
        chk("starve_a3", 32'(A3), 32'd9);
        chk("starve_mor", 32'(MemOrReg), 32'd1);
        #1 chk("starve_alu_back", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        chk("starve_alu_wr", 32'(MemOrReg), 32'd0);
        step();

        // Full buffer with ALU held
        alu_valid = 1'b1; alu_rd = 5'd2; alu_result = 32'h22;
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hA;
        step();
        ld_rd = 5'd11; ld_data = 32'hB;
        #1 chk("full_alurdy_b", 32'(alu_ready), 32'd1);
        step();
        ld_valid = 1'b0;
        #1 chk("full_ldrdy", 32'(ld_ready), 32'd0);
        chk("full_alustall", 32'(alu_ready), 32'd0);
        step();
        alu_valid = 1'b0;
        chk("full_a3", 32'(A3), 32'd10);
        chk("full_wd3", WD3, 32'hA);
        step();
        chk("full_a3_2", 32'(A3), 32'd11);
        chk("full_mor_2", 32'(MemOrReg), 32'd1);
        step();

        // Same-rd ordering
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        step();
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 32'h700;
        #1 chk("waw_alustall", 32'(alu_ready), 32'd0);
        step();
        chk("waw_ld_wd3", WD3, 32'h77);
        chk("waw_ld_mor", 32'(MemOrReg), 32'd1);
        #1 chk("waw_alurdy", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        chk("waw_alu_wd3", WD3, 32'h700);
        chk("waw_alu_a3", 32'(A3), 32'd7);

        // rd 0 write suppressed
        alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'hFFFF;
        #1 chk("rd0_alurdy", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        chk("rd0_we3", 32'(WE3), 32'd0);

        // Reset with two buffered loads
        alu_valid = 1'b1; alu_rd = 5'd4; alu_result = 32'h44;
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hC;
        step();
        ld_rd = 5'd13; ld_data = 32'hD;
        step();
        ld_valid = 1'b0;
        chk("pre_rst_pend", 32'(ld_pending), 32'd1);
        chk("pre_rst_ldrdy", 32'(ld_ready), 32'd0);
        #2 rst_n = 1'b0;
        alu_valid = 1'b0;
        #1 chk("arst_pend", 32'(ld_pending), 32'd0);
        chk("arst_ldrdy", 32'(ld_ready), 32'd1);
        chk("arst_we3", 32'(WE3), 32'd0);
        step();
        #3 rst_n = 1'b1;
        step();
        chk("rel_we3_a", 32'(WE3), 32'd0);
        step();
        chk("rel_we3_b", 32'(WE3), 32'd0);
        chk("rel_pend", 32'(ld_pending), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
